aes_mix_columns: RTL and testbench

- AES MixColumns stage for the 128-bit round datapath.
- Consumes the ShiftRows state and produces the state that feeds AddRoundKey.
- Built on the same GF(2^8) arithmetic as the GF multiplier: xtime with reduction polynomial 0x11B, and XOR as addition.
- Processes the state column-serially under a start/done pulse protocol. o_done is a one-tick pulse.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_mix_columns_if.sv | 33 +++
 rtl/aes_mix_col.sv | 45 ++++
 rtl/aes_mix_columns.sv | 106 ++++++++++
 tb/tb_aes_mix_columns.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) constants, column/state types, MixColumns FSM states.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam int STATE_W  = 128;
    localparam int BYTE_W   = 8;
    localparam int NUM_COLS = 4;
    localparam int COL_W    = 4 * BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Column 0 is the most significant word, matching byte k = state[127-8k -: 8].
    typedef logic [0:NUM_COLS-1][COL_W-1:0] cols_t;

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mix_columns_if.sv
// Start/done bundle for aes_mix_columns; i_inv exists only with AES_INV_MIX_COLUMNS_EN.
interface aes_mix_columns_if;
    import aes_pkg::*;

    // i_start is a request honoured only while o_busy=0; o_done pulses for one
    // cycle when o_state holds the result, which stays put until the next accepted start.
    logic               i_start;
    logic [STATE_W-1:0] i_state;
`ifdef AES_INV_MIX_COLUMNS_EN
    logic               i_inv;
`endif
    logic [STATE_W-1:0] o_state;
    logic               o_busy;
    logic               o_done;
    state_t             dbg_state;

    modport master (
        output i_start, i_state,
`ifdef AES_INV_MIX_COLUMNS_EN
        output i_inv,
`endif
        input  o_state, o_busy, o_done, dbg_state
    );

    modport slave (
        input  i_start, i_state,
`ifdef AES_INV_MIX_COLUMNS_EN
        input  i_inv,
`endif
        output o_state, o_busy, o_done, dbg_state
    );

endinterface

// File: rtl/aes_mix_col.sv
// One-column (Inv)MixColumns, purely combinational; inverse select only with AES_INV_MIX_COLUMNS_EN.
module aes_mix_col
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col,
`ifdef AES_INV_MIX_COLUMNS_EN
    input  logic             inv,
`endif
    output logic [COL_W-1:0] res
);

    logic [BYTE_W-1:0] a  [NUM_COLS];
    logic [BYTE_W-1:0] x2 [NUM_COLS];
    logic [BYTE_W-1:0] fb [NUM_COLS];
`ifdef AES_INV_MIX_COLUMNS_EN
    logic [BYTE_W-1:0] x4 [NUM_COLS];
    logic [BYTE_W-1:0] x8 [NUM_COLS];
    logic [BYTE_W-1:0] ib [NUM_COLS];
`endif

    for (genvar i = 0; i < NUM_COLS; i++) begin : g_byte
        localparam int I1 = (i + 1) % NUM_COLS;
        localparam int I2 = (i + 2) % NUM_COLS;
        localparam int I3 = (i + 3) % NUM_COLS;

        assign a[i]  = col[COL_W-1-BYTE_W*i -: BYTE_W];
        assign x2[i] = xtime(a[i]);
        // Each output row uses the coefficient row rotated by its own index.
        assign fb[i] = x2[i] ^ (x2[I1] ^ a[I1]) ^ a[I2] ^ a[I3];

`ifdef AES_INV_MIX_COLUMNS_EN
        assign x4[i] = xtime(x2[i]);
        assign x8[i] = xtime(x4[i]);
        // 14 = 8^4^2, 11 = 8^2^1, 13 = 8^4^1, 9 = 8^1
        assign ib[i] = (x8[i]  ^ x4[i]  ^ x2[i])
                     ^ (x8[I1] ^ x2[I1] ^ a[I1])
                     ^ (x8[I2] ^ x4[I2] ^ a[I2])
                     ^ (x8[I3] ^ a[I3]);
        assign res[COL_W-1-BYTE_W*i -: BYTE_W] = inv ? ib[i] : fb[i];
`else
        assign res[COL_W-1-BYTE_W*i -: BYTE_W] = fb[i];
`endif
    end

endmodule

// File: rtl/aes_mix_columns.sv
// Column-serial AES MixColumns with start/done protocol; AES_INV_MIX_COLUMNS_EN adds InvMixColumns.
module aes_mix_columns
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    aes_mix_columns_if.slave bus
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
        $fatal(1, "aes_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(NUM_COLS - COLS_PER_CYCLE);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    cols_t      work_q, work_d, upd;
`ifdef AES_INV_MIX_COLUMNS_EN
    logic       inv_q, inv_d;
`endif

    logic [COL_W-1:0] mc_in  [COLS_PER_CYCLE];
    logic [COL_W-1:0] mc_out [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        logic [1:0] idx;
        assign idx      = cnt_q + 2'(g);
        assign mc_in[g] = work_q[idx];

        aes_mix_col u_col (
            .col (mc_in[g]),
`ifdef AES_INV_MIX_COLUMNS_EN
            .inv (inv_q),
`endif
            .res (mc_out[g])
        );
    end

    always_comb begin
        upd = work_q;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            upd[cnt_q + 2'(g)] = mc_out[g];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
`ifdef AES_INV_MIX_COLUMNS_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts a new start directly so back-to-back runs need no idle cycle.
                if (bus.i_start) begin
                    work_d  = cols_t'(bus.i_state);
                    cnt_d   = 2'd0;
`ifdef AES_INV_MIX_COLUMNS_EN
                    inv_d   = bus.i_inv;
`endif
                    state_d = COL;
                end else begin
                    state_d = IDLE;
                end
            end
            COL: begin
                work_d = upd;
                cnt_d  = cnt_q + CNT_STEP;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 2'd0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            work_q  <= '0;
`ifdef AES_INV_MIX_COLUMNS_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
`ifdef AES_INV_MIX_COLUMNS_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign bus.o_state   = work_q;
    assign bus.o_busy    = (state_q == COL);
    assign bus.o_done    = (state_q == DONE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_aes_mix_columns.sv
// Directed bench for aes_mix_columns at 1/2/4 columns per cycle; inverse checks under AES_INV_MIX_COLUMNS_EN.
module tb_aes_mix_columns;
    import aes_pkg::*;

    localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
    localparam logic [127:0] V3_IN  = 128'h2d26314c_d4d4d4d5_db135345_f20a225c;
    localparam logic [127:0] V3_OUT = 128'h4d7ebdf8_d5d5d7d6_8e4da1bc_9fdc589d;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] din = '0;
`ifdef AES_INV_MIX_COLUMNS_EN
    logic         inv = 1'b0;
`endif

    int           n_tests = 0;
    int           n_fail = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    aes_mix_columns_if if1 ();
    aes_mix_columns_if if2 ();
    aes_mix_columns_if if4 ();

    assign if1.i_start = start;
    assign if2.i_start = start;
    assign if4.i_start = start;
    assign if1.i_state = din;
    assign if2.i_state = din;
    assign if4.i_state = din;
`ifdef AES_INV_MIX_COLUMNS_EN
    assign if1.i_inv = inv;
    assign if2.i_inv = inv;
    assign if4.i_inv = inv;
`endif

    aes_mix_columns #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    aes_mix_columns #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    aes_mix_columns #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        check(tag, {127'b0, got}, {127'b0, exp});
    endtask

    // One operation on all three instances; outputs sampled on the falling edge.
    task automatic run_op(input logic [127:0] d, input logic [127:0] e, input string tag);
        logic [127:0] e1;
        @(negedge clk);
        start = 1'b1;
        din   = d;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        din   = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int k = 1; k <= 6; k++) begin
            check_bit($sformatf("%s_done1_k%0d", tag, k), if1.o_done, k == 5);
            check_bit($sformatf("%s_done2_k%0d", tag, k), if2.o_done, k == 3);
            check_bit($sformatf("%s_done4_k%0d", tag, k), if4.o_done, k == 2);
            check_bit($sformatf("%s_busy1_k%0d", tag, k), if1.o_busy, k <= 4);
            check_bit($sformatf("%s_busy2_k%0d", tag, k), if2.o_busy, k <= 2);
            check_bit($sformatf("%s_busy4_k%0d", tag, k), if4.o_busy, k <= 1);
            if (k == 5) begin
                e1 = exp_q.pop_front();
                check($sformatf("%s_state1", tag), if1.o_state, e1);
            end
            if (k == 6) check($sformatf("%s_hold1", tag), if1.o_state, e);
            if (k == 3) check($sformatf("%s_state2", tag), if2.o_state, e);
            if (k == 2) check($sformatf("%s_state4", tag), if4.o_state, e);
            if (k < 6) @(negedge clk);
        end
    endtask

`ifdef AES_INV_MIX_COLUMNS_EN
    task automatic do_op(input logic [127:0] d, input logic iv, output logic [127:0] r);
        @(negedge clk);
        start = 1'b1;
        din   = d;
        inv   = iv;
        @(negedge clk);
        start = 1'b0;
        inv   = ~iv;
        for (int t = 0; t < 10 && !if1.o_done; t++) @(negedge clk);
        check_bit("rt_done_wait", if1.o_done, 1'b1);
        r = if1.o_state;
        @(negedge clk);
    endtask
`endif

    initial begin
        repeat (2) @(negedge clk);
        check("rst_state", if1.o_state, 128'h0);
        check_bit("rst_busy", if1.o_busy, 1'b0);
        check_bit("rst_done", if1.o_done, 1'b0);
        check({"rst_fsm"}, {126'b0, if1.dbg_state}, {126'b0, IDLE});
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", if1.o_state, 128'h0);
        check_bit("post_rst_busy", if1.o_busy, 1'b0);

        run_op(V1_IN, V1_OUT, "fips");
        run_op(V2_IN, V2_OUT, "col_d4");
        run_op(V3_IN, V3_OUT, "mixed");

        // Start during COL is ignored; start in DONE is taken without a gap.
        @(negedge clk);
        start = 1'b1;
        din   = V1_IN;
        @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            check_bit($sformatf("b2b_busy1_k%0d", k), if1.o_busy, (k >= 1 && k <= 4) || (k >= 6 && k <= 9));
            check_bit($sformatf("b2b_done1_k%0d", k), if1.o_done, k == 5 || k == 10);
            if (k == 5) check("b2b_first", if1.o_state, V1_OUT);
            if (k == 10) check("b2b_second", if1.o_state, V2_OUT);
            if (k == 2) begin
                start = 1'b1;
                din   = V3_IN;
            end else if (k == 5) begin
                start = 1'b1;
                din   = V2_IN;
            end else begin
                start = 1'b0;
                din   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            @(negedge clk);
        end

        // Reset in the third COL cycle aborts the operation.
        start = 1'b1;
        din   = V1_IN;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_bit("abort_busy_before", if1.o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_state", if1.o_state, 128'h0);
        check_bit("abort_busy", if1.o_busy, 1'b0);
        check_bit("abort_done", if1.o_done, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_bit($sformatf("abort_nodone_%0d", k), if1.o_done, 1'b0);
        end
        rst_n = 1'b1;
        run_op(V2_IN, V2_OUT, "after_rst");

`ifdef AES_INV_MIX_COLUMNS_EN
        inv = 1'b1;
        run_op(V1_OUT, V1_IN, "inv_fips");
        inv = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            logic [127:0] orig, fwd, back;
            orig = {$urandom(), $urandom(), $urandom(), $urandom()};
            do_op(orig, 1'b0, fwd);
            do_op(fwd, 1'b1, back);
            check($sformatf("roundtrip_%0d", n), back, orig);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
